debug_slave_cmd_queue: RTL and testbench

Next-generation system-clock side of the Nios II JTAG debug slave. It synchronises virtual-JTAG update strobes into clk and captures the IR and shift-register word into a parametrised command FIFO. Commands are then issued as single-cycle take_action/take_no_action pulses under a ready handshake from the CPU debug core. Unlike the previous generation, back-to-back JTAG updates are queued instead of overwritten, SR/IR widths are generic, and overflow is reported.

---
 rtl/debug_slave_cmd_queue.sv | 204 ++++++++++++++++++++
 tb/tb_debug_slave_cmd_queue.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_slave_cmd_queue.sv
// System-clock side of the JTAG debug slave: synchronised update strobes feed a command FIFO
// that issues decoded single-cycle pulses. Define DEBUG_SLAVE_CMD_STATS_EN for push/drop counters.
module debug_slave_cmd_queue #(
    parameter int IR_W        = 2,
    parameter int SR_W        = 38,
    parameter int SYNC_STAGES = 2,
    parameter int CMD_DEPTH   = 4,
    parameter int TRC_BIT     = 15
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [IR_W-1:0]            ir_in,
    input  logic [SR_W-1:0]            sr,
    input  logic                       vs_uir,
    input  logic                       vs_udr,
    input  logic                       cmd_ready,
    input  logic                       ovf_clr,
    output logic [SR_W-1:0]            jdo,
    output logic                       take_action_ocimem_a,
    output logic                       take_action_ocimem_b,
    output logic                       take_no_action_ocimem_a,
    output logic                       take_action_break_a,
    output logic                       take_action_break_b,
    output logic                       take_action_break_c,
    output logic                       take_no_action_break_a,
    output logic                       take_no_action_break_b,
    output logic                       take_no_action_break_c,
    output logic                       take_action_tracectrl,
    output logic                       cmd_pending,
    output logic                       cmd_overflow,
    output logic [$clog2(CMD_DEPTH):0] fifo_level
`ifdef DEBUG_SLAVE_CMD_STATS_EN
    ,
    output logic [15:0]                cmd_count,
    output logic [15:0]                drop_count
`endif
);

    localparam int PTR_W = $clog2(CMD_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int ARM_W = $clog2(SYNC_STAGES + 2);
    localparam logic [ARM_W-1:0] ARM_INIT = ARM_W'(SYNC_STAGES + 1);
    localparam int A_BIT = SR_W - 1;
    localparam int B_BIT = SR_W - 2;
    localparam int C_BIT = SR_W - 3;
    localparam int D_BIT = SR_W - 4;

    logic [SYNC_STAGES-1:0] uir_sync, udr_sync;
    logic                   uir_prev, udr_prev;
    logic                   uir_rise_q, udr_rise_q;
    logic [ARM_W-1:0]       arm_cnt;
    logic [IR_W-1:0]        ir_q, ir_sel;

    logic [1:0]             mem_op [CMD_DEPTH];
    logic [SR_W-1:0]        mem_sr [CMD_DEPTH];
    logic [PTR_W-1:0]       wr_ptr, rd_ptr;
    logic [LVL_W-1:0]       level_nxt;
    logic                   full, push, pop, ovf_set;
    logic [1:0]             head_op;
    logic [SR_W-1:0]        head_sr;

    logic dec_oci_a, dec_oci_b, dec_no_oci_a;
    logic dec_brk_a, dec_brk_b, dec_brk_c;
    logic dec_no_brk_a, dec_no_brk_b, dec_no_brk_c;
    logic dec_trc;

    logic uir_s, udr_s;
    assign uir_s = uir_sync[SYNC_STAGES-1];
    assign udr_s = udr_sync[SYNC_STAGES-1];

    // A same-cycle IR update takes precedence over the previously captured IR.
    always_comb begin
        ir_sel    = uir_rise_q ? ir_in : ir_q;
        full      = (fifo_level == LVL_W'(CMD_DEPTH));
        pop       = (fifo_level != '0) && cmd_ready;
        push      = udr_rise_q && (!full || pop);
        ovf_set   = udr_rise_q && full && !pop;
        level_nxt = fifo_level;
        if (push && !pop)
            level_nxt = fifo_level + LVL_W'(1);
        else if (pop && !push)
            level_nxt = fifo_level - LVL_W'(1);
        head_op = mem_op[rd_ptr];
        head_sr = mem_sr[rd_ptr];
    end

    always_comb begin
        dec_oci_a    = 1'b0;
        dec_oci_b    = 1'b0;
        dec_no_oci_a = 1'b0;
        dec_brk_a    = 1'b0;
        dec_brk_b    = 1'b0;
        dec_brk_c    = 1'b0;
        dec_no_brk_a = 1'b0;
        dec_no_brk_b = 1'b0;
        dec_no_brk_c = 1'b0;
        dec_trc      = 1'b0;
        case (head_op)
            2'b00: begin
                if (head_sr[C_BIT])      dec_oci_b    = 1'b1;
                else if (head_sr[D_BIT]) dec_oci_a    = 1'b1;
                else                     dec_no_oci_a = 1'b1;
            end
            2'b10: begin
                if (!head_sr[B_BIT]) begin
                    dec_brk_a    = head_sr[A_BIT];
                    dec_no_brk_a = !head_sr[A_BIT];
                end else if (!head_sr[C_BIT]) begin
                    dec_brk_b    = head_sr[A_BIT];
                    dec_no_brk_b = !head_sr[A_BIT];
                end else begin
                    dec_brk_c    = head_sr[A_BIT];
                    dec_no_brk_c = !head_sr[A_BIT];
                end
            end
            2'b11:   dec_trc = head_sr[TRC_BIT];
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            uir_sync                <= '0;
            udr_sync                <= '0;
            uir_prev                <= 1'b0;
            udr_prev                <= 1'b0;
            uir_rise_q              <= 1'b0;
            udr_rise_q              <= 1'b0;
            arm_cnt                 <= ARM_INIT;
            ir_q                    <= '0;
            wr_ptr                  <= '0;
            rd_ptr                  <= '0;
            fifo_level              <= '0;
            cmd_pending             <= 1'b0;
            cmd_overflow            <= 1'b0;
            jdo                     <= '0;
            take_action_ocimem_a    <= 1'b0;
            take_action_ocimem_b    <= 1'b0;
            take_no_action_ocimem_a <= 1'b0;
            take_action_break_a     <= 1'b0;
            take_action_break_b     <= 1'b0;
            take_action_break_c     <= 1'b0;
            take_no_action_break_a  <= 1'b0;
            take_no_action_break_b  <= 1'b0;
            take_no_action_break_c  <= 1'b0;
            take_action_tracectrl   <= 1'b0;
        end else begin
            uir_sync <= {uir_sync[SYNC_STAGES-2:0], vs_uir};
            udr_sync <= {udr_sync[SYNC_STAGES-2:0], vs_udr};
            uir_prev <= uir_s;
            udr_prev <= udr_s;
            // Edges are suppressed until the synchroniser has flushed post-reset levels.
            if (arm_cnt != '0)
                arm_cnt <= arm_cnt - ARM_W'(1);
            uir_rise_q <= (arm_cnt == '0) && uir_s && !uir_prev;
            udr_rise_q <= (arm_cnt == '0) && udr_s && !udr_prev;

            if (uir_rise_q)
                ir_q <= ir_in;
            if (push) begin
                mem_op[wr_ptr] <= ir_sel[1:0];
                mem_sr[wr_ptr] <= sr;
                wr_ptr         <= wr_ptr + PTR_W'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            fifo_level  <= level_nxt;
            cmd_pending <= (level_nxt != '0);

            if (ovf_set)
                cmd_overflow <= 1'b1;
            else if (ovf_clr)
                cmd_overflow <= 1'b0;

            if (pop)
                jdo <= head_sr;
            take_action_ocimem_a    <= pop && dec_oci_a;
            take_action_ocimem_b    <= pop && dec_oci_b;
            take_no_action_ocimem_a <= pop && dec_no_oci_a;
            take_action_break_a     <= pop && dec_brk_a;
            take_action_break_b     <= pop && dec_brk_b;
            take_action_break_c     <= pop && dec_brk_c;
            take_no_action_break_a  <= pop && dec_no_brk_a;
            take_no_action_break_b  <= pop && dec_no_brk_b;
            take_no_action_break_c  <= pop && dec_no_brk_c;
            take_action_tracectrl   <= pop && dec_trc;
        end
    end

`ifdef DEBUG_SLAVE_CMD_STATS_EN
    always_ff @(posedge clk) begin
        if (!reset_n || ovf_clr) begin
            cmd_count  <= '0;
            drop_count <= '0;
        end else begin
            if (push && cmd_count != '1)
                cmd_count <= cmd_count + 16'd1;
            if (ovf_set && drop_count != '1)
                drop_count <= drop_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_debug_slave_cmd_queue.sv
// Scoreboard bench for debug_slave_cmd_queue: stimulus queues expected pulses, a monitor checks them.
module tb_debug_slave_cmd_queue;

    localparam logic [9:0] P_OCI_A    = 10'b1000000000;
    localparam logic [9:0] P_OCI_B    = 10'b0100000000;
    localparam logic [9:0] P_NO_OCI_A = 10'b0010000000;
    localparam logic [9:0] P_BRK_A    = 10'b0001000000;
    localparam logic [9:0] P_BRK_B    = 10'b0000100000;
    localparam logic [9:0] P_BRK_C    = 10'b0000010000;
    localparam logic [9:0] P_NO_BRK_A = 10'b0000001000;
    localparam logic [9:0] P_NO_BRK_B = 10'b0000000100;
    localparam logic [9:0] P_NO_BRK_C = 10'b0000000010;
    localparam logic [9:0] P_TRC      = 10'b0000000001;
    localparam int LAT = 5; // drive instant to pulse-visible negedge

    logic        clk, reset_n, vs_uir, vs_udr, cmd_ready, ovf_clr;
    logic [1:0]  ir_in;
    logic [37:0] sr, jdo;
    logic        t_oci_a, t_oci_b, t_no_oci_a;
    logic        t_brk_a, t_brk_b, t_brk_c, t_no_brk_a, t_no_brk_b, t_no_brk_c, t_trc;
    logic        cmd_pending, cmd_overflow;
    logic [2:0]  fifo_level;
`ifdef DEBUG_SLAVE_CMD_STATS_EN
    logic [15:0] cmd_count, drop_count;
`endif

    debug_slave_cmd_queue #(.IR_W(2), .SR_W(38), .SYNC_STAGES(2), .CMD_DEPTH(4), .TRC_BIT(15)) dut (
        .clk(clk), .reset_n(reset_n), .ir_in(ir_in), .sr(sr),
        .vs_uir(vs_uir), .vs_udr(vs_udr), .cmd_ready(cmd_ready), .ovf_clr(ovf_clr),
        .jdo(jdo),
        .take_action_ocimem_a(t_oci_a), .take_action_ocimem_b(t_oci_b),
        .take_no_action_ocimem_a(t_no_oci_a),
        .take_action_break_a(t_brk_a), .take_action_break_b(t_brk_b),
        .take_action_break_c(t_brk_c),
        .take_no_action_break_a(t_no_brk_a), .take_no_action_break_b(t_no_brk_b),
        .take_no_action_break_c(t_no_brk_c),
        .take_action_tracectrl(t_trc),
        .cmd_pending(cmd_pending), .cmd_overflow(cmd_overflow), .fifo_level(fifo_level)
`ifdef DEBUG_SLAVE_CMD_STATS_EN
        , .cmd_count(cmd_count), .drop_count(drop_count)
`endif
    );

    typedef struct {
        logic [9:0]  pulses;
        logic [37:0] jdo;
        int          cyc;
        bit          b2b;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   last_cyc = -100;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    always @(negedge clk) begin : monitor
        logic [9:0] pv;
        exp_t e;
        pv = {t_oci_a, t_oci_b, t_no_oci_a, t_brk_a, t_brk_b, t_brk_c,
              t_no_brk_a, t_no_brk_b, t_no_brk_c, t_trc};
        if (reset_n && pv != '0) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_pulse: got pulses=%b jdo=%h, required none", pv, jdo);
            end else begin
                e = sb.pop_front();
                if (pv !== e.pulses || jdo !== e.jdo) begin
                    n_err++;
                    $display("FAIL cmd_issue: got pulses=%b jdo=%h, required pulses=%b jdo=%h",
                             pv, jdo, e.pulses, e.jdo);
                end
                if (e.cyc >= 0) begin
                    n_cmp++;
                    if (cyc != e.cyc) begin
                        n_err++;
                        $display("FAIL latency: got cycle %0d, required cycle %0d", cyc, e.cyc);
                    end
                end
                if (e.b2b) begin
                    n_cmp++;
                    if (cyc != last_cyc + 1) begin
                        n_err++;
                        $display("FAIL back_to_back: got cycle %0d, required cycle %0d", cyc, last_cyc + 1);
                    end
                end
            end
            last_cyc = cyc;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_uir(input logic [1:0] ir);
        ir_in  = ir;
        vs_uir = 1'b1;
        tick(4);
        vs_uir = 1'b0;
        tick(4);
    endtask

    // exp_p == 0 means no pulse is expected from this update.
    task automatic send_udr(input logic [37:0] s, input bit with_uir, input logic [1:0] ir,
                            input logic [9:0] exp_p, input bit chk_lat, input bit b2b);
        exp_t e;
        if (exp_p != '0) begin
            e.pulses = exp_p;
            e.jdo    = s;
            e.cyc    = chk_lat ? cyc + LAT : -1;
            e.b2b    = b2b;
            sb.push_back(e);
        end
        if (with_uir) ir_in = ir;
        sr     = s;
        vs_udr = 1'b1;
        vs_uir = with_uir;
        tick(4);
        vs_udr = 1'b0;
        vs_uir = 1'b0;
        tick(4);
    endtask

    logic [37:0] s;
    logic [2:0]  pats [6];
    logic [9:0]  pexp [6];

    initial begin
        reset_n = 1'b0; vs_uir = 1'b0; vs_udr = 1'b1; cmd_ready = 1'b1; ovf_clr = 1'b0;
        ir_in = 2'b00; sr = '0;

        // Reset values, then a level held high through reset must not arm a command.
        tick(3);
        chk("rst_jdo", jdo, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_ovf", cmd_overflow, 0);
        chk("rst_pending", cmd_pending, 0);
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk("arm_pending", cmd_pending, 0);
        end
        vs_udr = 1'b0;
        tick(4);

        // Basic latency with the reset IR (op 00), D set, C clear.
        send_udr(38'h04_1234_5678, 1'b0, 2'b00, P_OCI_A, 1'b1, 1'b0);
        chk("basic_jdo", jdo, 38'h04_1234_5678);

        // Break decode sweep with IR = 10.
        send_uir(2'b10);
        pats[0] = 3'b100; pexp[0] = P_BRK_A;
        pats[1] = 3'b000; pexp[1] = P_NO_BRK_A;
        pats[2] = 3'b110; pexp[2] = P_BRK_B;
        pats[3] = 3'b010; pexp[3] = P_NO_BRK_B;
        pats[4] = 3'b111; pexp[4] = P_BRK_C;
        pats[5] = 3'b011; pexp[5] = P_NO_BRK_C;
        for (int i = 0; i < 6; i++) begin
            s = 38'h00_0000_5A5A;
            s[37:35] = pats[i];
            s[7:0] = 8'(i);
            send_udr(s, 1'b0, 2'b00, pexp[i], 1'b1, 1'b0);
        end

        // Fill the queue while the core is stalled, overflow on the fifth update.
        cmd_ready = 1'b0;
        pats[0] = 3'b100; pexp[0] = P_BRK_A;
        pats[1] = 3'b110; pexp[1] = P_BRK_B;
        pats[2] = 3'b111; pexp[2] = P_BRK_C;
        pats[3] = 3'b000; pexp[3] = P_NO_BRK_A;
        for (int i = 0; i < 4; i++) begin
            s = 38'h00_0000_1100;
            s[37:35] = pats[i];
            s[3:0] = 4'(i + 1);
            send_udr(s, 1'b0, 2'b00, pexp[i], 1'b0, i != 0);
        end
        chk("full_level", fifo_level, 4);
        chk("full_no_ovf", cmd_overflow, 0);
        send_udr(38'h10_0000_0BAD, 1'b0, 2'b00, '0, 1'b0, 1'b0);
        chk("ovf_level", fifo_level, 4);
        chk("ovf_flag", cmd_overflow, 1);
`ifdef DEBUG_SLAVE_CMD_STATS_EN
        chk("stat_cmd_count", cmd_count, 11);
        chk("stat_drop_count", drop_count, 1);
`endif
        cmd_ready = 1'b1;
        tick(6);
        chk("drain_level", fifo_level, 0);
        chk("ovf_sticky", cmd_overflow, 1);
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        chk("ovf_cleared", cmd_overflow, 0);
`ifdef DEBUG_SLAVE_CMD_STATS_EN
        chk("stat_cmd_clr", cmd_count, 0);
        chk("stat_drop_clr", drop_count, 0);
`endif

        // Simultaneous IR/DR update: new IR 11 must decode, not the held IR 10.
        s = 38'h20_0000_803C;
        send_udr(s, 1'b1, 2'b11, P_TRC, 1'b1, 1'b0);

        // Op 01 issues no pulse but still updates jdo.
        send_udr(38'h2A_5555_AAAA, 1'b1, 2'b01, '0, 1'b0, 1'b0);
        chk("op01_jdo", jdo, 38'h2A_5555_AAAA);

        // Reset with three queued ocimem commands: nothing may issue afterwards.
        cmd_ready = 1'b0;
        send_uir(2'b00);
        for (int i = 0; i < 3; i++)
            send_udr(38'h04_0000_0000 | 38'(i), 1'b0, 2'b00, '0, 1'b0, 1'b0);
        chk("pre_rst_level", fifo_level, 3);
        chk("pre_rst_pending", cmd_pending, 1);
`ifdef DEBUG_SLAVE_CMD_STATS_EN
        chk("pre_rst_cmd_count", cmd_count, 5);
`endif
        reset_n = 1'b0;
        tick(1);
        chk("midrst_level", fifo_level, 0);
        chk("midrst_pending", cmd_pending, 0);
`ifdef DEBUG_SLAVE_CMD_STATS_EN
        chk("midrst_cmd_count", cmd_count, 0);
`endif
        reset_n = 1'b1;
        cmd_ready = 1'b1;
        tick(12);
        chk("post_rst_pending", cmd_pending, 0);
        chk("sb_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
